// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports (CPU, DMA) plus the
// memory-side access port. The arbiter uses the slave view; whatever drives
// the requests and models the memory uses the master view.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // DMA / debug requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;
  // Memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_done, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_done, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_done, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter. One access at a time goes through
// IDLE -> ACCESS -> DONE; the winner's command is latched on grant and held
// on the memory port for the whole access. An access that sees no mem_ready
// for TIMEOUT cycles is aborted with a one-cycle err pulse alongside done.
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16   // must be >= 2
) (
  input  logic         Clk,
  input  logic         Reset,  // asynchronous, active-low
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  // State and datapath registers; reset aborts any access in flight.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;   // CPU wins the first tie
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/timeout in ACCESS.
  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.cpu_req || bus.dma_req) begin
          if (bus.cpu_req && bus.dma_req)
            owner_d = (last_owner_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
          else
            owner_d = bus.cpu_req ? OWN_CPU : OWN_DMA;

          if (owner_d == OWN_CPU) begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end else begin
            we_d    = bus.dma_we;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
          end
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // mem_ready takes priority over a timeout landing on the same cycle.
        if (bus.mem_ready) begin
          state_d      = DONE;
          err_d        = 1'b0;
          last_owner_d = owner_q;
          if (owner_q == OWN_CPU) cpu_rdata_d = we_q ? '0 : bus.mem_rdata;
          else                    dma_rdata_d = we_q ? '0 : bus.mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (owner_q == OWN_CPU) cpu_rdata_d = '0;
          else                    dma_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; memory command comes from latched values.
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_done  = (state_q == DONE) && (owner_q == OWN_CPU);
  assign bus.dma_done  = (state_q == DONE) && (owner_q == OWN_DMA);
  assign bus.err       = (state_q == DONE) && err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: requester tasks push expected completions into
// per-port queues, a memory responder models wait states and records what
// appeared on the memory port, and a monitor pops and compares on each done.
module tb_mem_arbiter;

  localparam int NEVER = 1000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          en_cycles;
  } exp_t;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t cpu_q[$];
  exp_t dma_q[$];
  bit   done_order[$];
  int   mem_wait = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: ready after mem_wait stall cycles; junk data otherwise.
  int          c;
  bit          in_acc = 1'b0;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we;
  bit          acc_stable;
  int          acc_cycles;

  always @(posedge clk) begin
    #1;
    if (bus.mem_en) begin
      if (!in_acc) begin
        in_acc     = 1'b1;
        c          = 0;
        acc_addr   = bus.mem_addr;
        acc_we     = bus.mem_we;
        acc_wdata  = bus.mem_wdata;
        acc_stable = 1'b1;
        acc_cycles = 0;
      end else if (bus.mem_addr !== acc_addr || bus.mem_we !== acc_we ||
                   bus.mem_wdata !== acc_wdata) begin
        acc_stable = 1'b0;
      end
      acc_cycles++;
      if (c == mem_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = acc_we ? 32'hBAD0BAD0 : pat(acc_addr);
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h13572468;
      end
      c++;
    end else begin
      in_acc = 1'b0;
      check("mem_we_outside_access", bus.mem_we, 1'b0);
      // Stray ready outside an access must be ignored.
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hFFFF0000;
    end
  end

  task automatic completion(input bit port);
    exp_t e;
    if (port ? (dma_q.size() == 0) : (cpu_q.size() == 0)) begin
      check(port ? "dma_unexpected_done" : "cpu_unexpected_done", 1'b1, 1'b0);
      return;
    end
    e = port ? dma_q.pop_front() : cpu_q.pop_front();
    done_order.push_back(port);
    check(port ? "dma_rdata" : "cpu_rdata", port ? bus.dma_rdata : bus.cpu_rdata, e.rdata);
    check("err_at_done", bus.err, e.err);
    check("mem_addr", acc_addr, e.addr);
    check("mem_we", acc_we, e.we);
    check("mem_wdata", acc_wdata, e.wdata);
    check("mem_cmd_stable", acc_stable, 1'b1);
    check("mem_en_cycles", acc_cycles, e.en_cycles);
  endtask

  // Monitor: compare each done pulse against the head of its port's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cpu_done || bus.dma_done)
        check("single_done", bus.cpu_done & bus.dma_done, 1'b0);
      if (bus.cpu_done) completion(1'b0);
      if (bus.dma_done) completion(1'b1);
      if (!bus.cpu_done && !bus.dma_done)
        check("err_outside_done", bus.err, 1'b0);
    end
  end

  // Issue one access on a port (caller sits just after a rising edge) and
  // wait, bounded, for its done pulse.
  task automatic access(input bit port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int en_cycles, input int exp_lat,
                        input bit release_req);
    exp_t e;
    bit   seen = 1'b0;
    int   lat = 0;
    e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = exp_rd; e.err = exp_err; e.en_cycles = en_cycles;
    if (port) begin
      dma_q.push_back(e);
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      cpu_q.push_back(e);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (port ? bus.dma_done : bus.cpu_done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (!port) check("cpu_stall_waiting", bus.cpu_stall, 1'b1);
    end
    if (!seen) begin
      check(port ? "dma_done_timeout" : "cpu_done_timeout", 1'b0, 1'b1);
      if (port) void'(dma_q.pop_back()); else void'(cpu_q.pop_back());
    end else begin
      if (!port) check("cpu_stall_at_done", bus.cpu_stall, 1'b0);
      if (exp_lat >= 0) check(port ? "dma_latency" : "cpu_latency", lat, exp_lat);
    end
    @(posedge clk);
    #1;
    if (release_req) begin
      if (port) bus.dma_req = 1'b0; else bus.cpu_req = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    exp_t e;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_cpu_done", bus.cpu_done, 1'b0);
    check("rst_dma_done", bus.dma_done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_dma_rdata", bus.dma_rdata, 32'h0);
    check("rst_cpu_stall", bus.cpu_stall, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both request right after reset and keep requesting: CPU, DMA, CPU, DMA
    done_order.delete();
    fork
      begin
        access(1'b0, 1'b0, 32'h300, 32'h0, pat(32'h300), 1'b0, 1, 2, 1'b0);
        access(1'b0, 1'b0, 32'h304, 32'h0, pat(32'h304), 1'b0, 1, 5, 1'b1);
      end
      begin
        access(1'b1, 1'b0, 32'h400, 32'h0, pat(32'h400), 1'b0, 1, 5, 1'b0);
        access(1'b1, 1'b0, 32'h404, 32'h0, pat(32'h404), 1'b0, 1, -1, 1'b1);
      end
    join
    check("grant_count", done_order.size(), 4);
    if (done_order.size() == 4) begin
      check("grant0_cpu", done_order[0], 1'b0);
      check("grant1_dma", done_order[1], 1'b1);
      check("grant2_cpu", done_order[2], 1'b0);
      check("grant3_dma", done_order[3], 1'b1);
    end
    check("cpu_rdata_hold", bus.cpu_rdata, pat(32'h304));

    // Zero-wait CPU read
    mem_wait = 0;
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 2, 1'b1);

    // DMA write with three wait cycles; CPU read data must hold
    mem_wait = 3;
    access(1'b1, 1'b1, 32'h200, 32'h55AA, 32'h0, 1'b0, 4, 5, 1'b1);
    check("cpu_rdata_hold_dma_wr", bus.cpu_rdata, 32'hDEADBEEF);
    check("dma_rdata_after_wr", bus.dma_rdata, 32'h0);

    // Timeout abort, then mem_ready on the last allowed cycle
    mem_wait = NEVER;
    access(1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 1'b1, 16, 17, 1'b1);
    mem_wait = 15;
    access(1'b0, 1'b0, 32'h604, 32'h0, pat(32'h604), 1'b0, 16, 17, 1'b1);

    // CPU write with one wait cycle clears cpu_rdata
    mem_wait = 1;
    access(1'b0, 1'b1, 32'h700, 32'hCAFEF00D, 32'h0, 1'b0, 2, 3, 1'b1);

    // Reset during an access wait, then the still-pending request completes
    mem_wait = NEVER;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h500; bus.cpu_wdata = '0;
    repeat (4) @(negedge clk);
    check("mem_en_before_reset", bus.mem_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mem_en_in_reset", bus.mem_en, 1'b0);
    check("cpu_done_in_reset", bus.cpu_done, 1'b0);
    check("err_in_reset", bus.err, 1'b0);
    check("cpu_stall_in_reset", bus.cpu_stall, 1'b1);
    mem_wait = 0;
    e.we = 1'b0; e.addr = 32'h500; e.wdata = '0;
    e.rdata = pat(32'h500); e.err = 1'b0; e.en_cycles = 1;
    cpu_q.push_back(e);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("cpu_done_after_reset", seen, 1'b1);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;

    repeat (3) @(negedge clk);
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("dma_queue_drained", dma_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_W, 32, data width
  ADDR_W, 32, byte address width
  TIMEOUT, 16, ACCESS cycles without mem_ready before abort (>=2)
REQ-002 Ports (name  direction  width  meaning):
  Clk        in   1       single clock, all state on rising edge
  Reset      in   1       asynchronous, active-low reset
  cpu_req    in   1       CPU (controller/datapath) access request, level
  cpu_we     in   1       CPU write enable
  cpu_addr   in   ADDR_W  CPU address
  cpu_wdata  in   DATA_W  CPU write data
  cpu_done   out  1       CPU access complete, 1-cycle pulse
  cpu_rdata  out  DATA_W  CPU read data, valid with cpu_done
  cpu_stall  out  1       cpu_req & ~cpu_done, holds controller state
  dma_req    in   1       DMA/debug access request, level
  dma_we     in   1       DMA write enable
  dma_addr   in   ADDR_W  DMA address
  dma_wdata  in   DATA_W  DMA write data
  dma_done   out  1       DMA access complete, 1-cycle pulse
  dma_rdata  out  DATA_W  DMA read data, valid with dma_done
  mem_en     out  1       memory access strobe
  mem_we     out  1       memory write enable
  mem_addr   out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
  mem_ready  in   1       memory completes current access
  err        out  1       timeout abort flag, 1-cycle pulse with done
REQ-003 Reset is asynchronous and active-low on Reset; one clock, Clk.

Function
REQ-004 FSM states IDLE, ACCESS, DONE; exactly one active.
REQ-005 IDLE: no request -> stay; any request -> register winner, latch its we/addr/wdata, go ACCESS.
REQ-006 Arbitration round-robin via last_owner bit: both requesting -> grant the one not served last; single requester -> granted regardless.
REQ-007 ACCESS: mem_en=1, mem_we/addr/wdata from latched values, constant for whole access; requester inputs ignored.
REQ-008 ACCESS with mem_ready=1 -> latch mem_rdata (0 for writes), go DONE, last_owner <= owner.
REQ-009 Wait counter starts at 0 on ACCESS entry, +1 per ACCESS cycle without mem_ready; reaching TIMEOUT-1 without mem_ready -> go DONE with err latched, rdata=0.
REQ-010 mem_ready and timeout in same cycle -> mem_ready wins, err=0.
REQ-011 DONE lasts exactly one cycle: owner's done=1, owner's rdata valid, err valid; other done=0; requests ignored; next state IDLE.
REQ-012 Requester deasserts req at the edge ending its done cycle; req still high in IDLE is a new request.
REQ-013 Latency: zero-wait memory -> req in IDLE cycle n, mem_en n+1, done n+2; each wait cycle adds 1.
REQ-014 rdata outputs hold last value until next done for that port; mem_en=0 and mem_we=0 outside ACCESS.
REQ-015 mem_ready outside ACCESS ignored.
REQ-016 cpu_stall combinational, per REQ-002.

Reset
REQ-017 Reset low -> IDLE, all done/err/mem_en/mem_we 0, rdata 0, mem_addr/mem_wdata 0, counter 0, last_owner=DMA (CPU wins first tie).
REQ-018 Reset mid-ACCESS aborts immediately, no done pulse; Reset release -> IDLE next edge.

Verification
REQ-019 CPU read 0x100, zero-wait, mem_rdata=0xDEADBEEF -> mem_en cycle 1 only, cpu_done+cpu_rdata=0xDEADBEEF cycle 2, err=0.
REQ-020 Both req after reset -> CPU first, DMA next; both held -> grants alternate CPU,DMA,CPU,DMA.
REQ-021 DMA write 0x200/0x55AA, mem_ready after 3 waits -> mem_we=1 4 cycles, addr/data stable, dma_done cycle 5, dma_rdata=0.
REQ-022 mem_ready never (TIMEOUT=16) -> mem_en 16 cycles, then done=1 err=1 rdata=0; mem_ready on cycle 16 -> err=0.
REQ-023 Reset low during ACCESS wait -> mem_en, done 0 immediately; after release, pending cpu_req completes normally.
REQ-024 cpu_req held, no memory response -> cpu_stall=1 until done cycle, 0 that cycle.
